// File: rtl/sbox_rnd_feeder.sv
// sbox_rnd_feeder: Galois-LFSR randomness source for the masked S-box buses.
// Optional macro FEEDER_RESEED_REQ_EN adds a periodic reseed request.
module sbox_rnd_feeder #(
    parameter int d          = 2,
    parameter int RND0_W     = 18,
    parameter int RND1_W     = 6,
    parameter int RND2_W     = 18,
    parameter int RND3_W     = 3,
    parameter int RESEED_LOG = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       seed_data,
    input  logic              seed_valid,
    output logic              seed_ready,
    input  logic              reseed,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic [RND0_W-1:0] rnd_bus0w,
    output logic [RND1_W-1:0] rnd_bus1w,
    output logic [RND2_W-1:0] rnd_bus2w,
    output logic [RND3_W-1:0] rnd_bus3w,
    output logic              reseed_req
);

    localparam int RND_TOT = RND0_W + RND1_W + RND2_W + RND3_W;
    localparam int L       = (RND_TOT + 31) / 32;
    localparam int LW      = 32 * L;
    localparam int IDX_W   = (L > 1) ? $clog2(L) : 1;
    localparam int OFF1    = RND0_W;
    localparam int OFF2    = OFF1 + RND1_W;
    localparam int OFF3    = OFF2 + RND2_W;

    localparam logic [31:0] TAPS = 32'h80200003;

    // Share count only has to agree with the S-box; reject nonsense values early.
    if (d < 1 || RESEED_LOG < 1 || RND_TOT < 1) begin : g_param_check
        $error("sbox_rnd_feeder: bad parameters");
    end

    typedef enum logic [0:0] {
        SEED = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LW-1:0]    lanes;
    logic [IDX_W-1:0] idx;
    logic             seed_acc;
    logic             hs;
    logic             last_word;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] sh;
        sh = s >> 1;
        return s[0] ? (sh ^ TAPS) : sh;
    endfunction

    assign seed_acc  = seed_valid && seed_ready;
    assign hs        = rnd_valid && rnd_ready;
    assign last_word = (idx == IDX_W'(L - 1));

    assign rnd_bus0w = lanes[0    +: RND0_W];
    assign rnd_bus1w = lanes[OFF1 +: RND1_W];
    assign rnd_bus2w = lanes[OFF2 +: RND2_W];
    assign rnd_bus3w = lanes[OFF3 +: RND3_W];

    // Next state and handshake outputs; reseed overrides everything.
    always_comb begin
        state_nxt  = state;
        seed_ready = 1'b0;
        rnd_valid  = 1'b0;
        unique case (state)
            SEED: begin
                seed_ready = 1'b1;
                if (seed_acc && last_word) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rnd_valid = 1'b1;
            end
            default: state_nxt = SEED;
        endcase
        if (reseed) begin
            state_nxt = SEED;
        end
    end

    // State register, lane loading during seeding and lane stepping on handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
            lanes <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            for (int i = 0; i < L; i++) begin
                if (seed_acc && idx == IDX_W'(i)) begin
                    lanes[32*i +: 32] <= (seed_data == 32'h0) ? 32'h1 : seed_data;
                end else if (hs) begin
                    lanes[32*i +: 32] <= lfsr_step(lanes[32*i +: 32]);
                end
            end
            if (reseed || (seed_acc && last_word)) begin
                idx <= '0;
            end else if (seed_acc) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef FEEDER_RESEED_REQ_EN
    logic [RESEED_LOG-1:0] step_cnt;
    logic                  req_q;

    // Count handshakes; raise a sticky request when the counter wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step_cnt <= '0;
            req_q    <= 1'b0;
        end else if (reseed) begin
            step_cnt <= '0;
            req_q    <= 1'b0;
        end else if (hs) begin
            step_cnt <= step_cnt + RESEED_LOG'(1);
            if (&step_cnt) begin
                req_q <= 1'b1;
            end
        end
    end

    assign reseed_req = req_q;
`else
    assign reseed_req = 1'b0;
`endif

endmodule
